branch_resolve_ctrl: RTL
========================

Name: branch_resolve_ctrl

Overview:
- Sequences early branch resolution in the decode stage.
- Detects data hazards on the branch comparator operands and drives forwarding selects for RD1/RD2.
- Stalls IF/ID when a forward cannot satisfy an operand, enables the comparator, then redirects the PC and flushes IF/ID on a taken branch.
- Keeps saturating performance counters for branches, taken branches and branch stall cycles.

Parameters:
- CNT_W, 32, width of each performance counter.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- hold  in  1  global pipeline freeze from memory or system.
- id_valid  in  1  ID stage holds a valid instruction.
- id_branch  in  1  ID instruction is a conditional branch.
- id_rs1  in  REG_AW  branch source register 1.
- id_rs2  in  REG_AW  branch source register 2.
- ex_regwrite  in  1  EX-stage instruction writes a register.
- ex_memread  in  1  EX-stage instruction is a load.
- ex_rd  in  REG_AW  EX-stage destination register.
- mem_regwrite  in  1  MEM-stage instruction writes a register.
- mem_memread  in  1  MEM-stage instruction is a load.
- mem_rd  in  REG_AW  MEM-stage destination register.
- wb_regwrite  in  1  WB-stage instruction writes a register.
- wb_rd  in  REG_AW  WB-stage destination register.
- branch_flag  in  1  comparator result, valid in the same cycle as cmp_en.
- cmp_en  out  1  branch_signal to the comparator.
- fwd_a  out  2  RD1 source: 00 register file, 01 MEM ALU result, 10 WB data.
- fwd_b  out  2  RD2 source, same encoding as fwd_a.
- stall  out  1  freeze PC and IF/ID; insert a bubble into ID/EX.
- pc_sel  out  1  1 selects the branch target for the next PC.
- flush_if_id  out  1  zero the IF/ID register.
- br_count  out  CNT_W  resolved branches.
- taken_count  out  CNT_W  taken branches.
- stall_count  out  CNT_W  cycles stalled for branch hazards.

Behaviour:
- Definitions:
  - "Dependent" means a stage writes a register, its rd is nonzero, and its rd equals id_rs1 or id_rs2.
  - br = id_valid & id_branch.
- FSM states:
  - S_IDLE: evaluate the current branch.
  - S_LDWAIT: forced second stall cycle for a load in EX.
- Transitions from S_IDLE when br=1 and hold=0, first matching rule wins:
  - (a) Dependent load in EX: stall=1, next state S_LDWAIT.
  - (b) Dependent non-load in EX: stall=1, stay in S_IDLE.
  - (c) Dependent load in MEM: stall=1, stay in S_IDLE.
  - (d) Otherwise resolve: stall=0, cmp_en=1, pc_sel=flush_if_id=branch_flag.
- S_LDWAIT: stall=1, cmp_en=0, next state S_IDLE unconditionally. The branch re-evaluates with the load now in WB.
- Forwarding, per operand, in priority order MEM then WB:
  - MEM dependent and not a load: 01.
  - Else WB dependent: 10.
  - Else: 00.
  - fwd_a/fwd_b are meaningful only when cmp_en=1 and are driven as 00 otherwise.
- Register x0 never creates a hazard or a forward.
- Outputs other than the counters are combinational from state and inputs. Latency:
  - Hazard-free branch: resolved in its first ID cycle.
  - ALU dependency or load in MEM: +1 cycle.
  - Load in EX: +2 cycles.
- hold=1:
  - State and counters frozen.
  - stall, cmp_en, pc_sel, flush_if_id all forced 0; the external freeze covers the pipeline.
  - fwd outputs forced to 00.
- br=0 in S_IDLE: all control outputs 0, no counter change.
- Counters, saturating at all-ones:
  - br_count +1 on each resolve.
  - taken_count +1 on each resolve with branch_flag=1.
  - stall_count +1 on each cycle with stall=1.
- Reset (rst=0, any time including mid-stall):
  - State goes to S_IDLE.
  - All counters go to 0.
  - All outputs go to 0 while reset is asserted.
- The flush is a single cycle: after a taken branch, IF/ID holds a bubble, so br=0 the next cycle.

Test Plan:
- Independent branch: rs1=1, rs2=2, no dependencies, branch_flag=1 -> same cycle cmp_en=1, pc_sel=1, flush_if_id=1, stall=0; br_count=1, taken_count=1.
- ALU dependency: ex_rd=3 with regwrite, rs1=3 -> cycle 1 stall=1, stall_count=1. Cycle 2 with mem_rd=3 -> fwd_a=01, cmp_en=1; branch_flag=0 gives pc_sel=0.
- Load in EX: ex_memread=1, ex_rd=5, rs2=5 -> stall for 2 cycles with the state passing through S_LDWAIT. Cycle 3 with wb_rd=5 -> fwd_b=10, cmp_en=1; stall_count=2.
- x0 and priority: ex_rd=0 with regwrite, rs1=0 -> no stall. Both mem_rd=4 (ALU) and wb_rd=4 with rs1=4 -> fwd_a=01.
- Hold during S_LDWAIT: hold=1 for 3 cycles -> state stays S_LDWAIT, outputs 0, counters unchanged. Release hold -> one stall cycle, then resolve.
- Async reset mid-stall: rst low between edges -> outputs and counters read 0 immediately. Saturation: preload counters at all-ones (CNT_W=4 build) -> a further taken branch leaves them at 15.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - decode-stage early branch resolution controller
//
// Purpose:
//   Resolves conditional branches in ID. Detects hazards on the branch
//   comparator operands, stalls IF/ID when forwarding cannot supply an
//   operand, drives the RD1/RD2 forwarding selects, enables the comparator,
//   and redirects the PC / flushes IF/ID on a taken branch. Keeps saturating
//   counters of resolved branches, taken branches and branch stall cycles.
//
// Ports:
//   i_clk             clock, rising edge
//   i_rst             asynchronous active-low reset
//   i_hold            global pipeline freeze
//   i_id_valid        ID holds a valid instruction
//   i_id_branch       ID instruction is a conditional branch
//   i_id_rs1/rs2      branch source registers
//   i_ex_regwrite     EX writes a register
//   i_ex_memread      EX is a load
//   i_ex_rd           EX destination
//   i_mem_regwrite    MEM writes a register
//   i_mem_memread     MEM is a load
//   i_mem_rd          MEM destination
//   i_wb_regwrite     WB writes a register
//   i_wb_rd           WB destination
//   i_branch_flag     comparator result, valid with o_cmp_en
//   o_cmp_en          comparator enable
//   o_fwd_a/o_fwd_b   operand source: 00 regfile, 01 MEM ALU, 10 WB data
//   o_stall           freeze PC and IF/ID, bubble into ID/EX
//   o_pc_sel          select branch target for next PC
//   o_flush_if_id     zero IF/ID
//   o_br_count        resolved branches (saturating)
//   o_taken_count     taken branches (saturating)
//   o_stall_count     branch stall cycles (saturating)

module branch_resolve_ctrl #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hold,
  input  logic              i_id_valid,
  input  logic              i_id_branch,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_ex_regwrite,
  input  logic              i_ex_memread,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_mem_regwrite,
  input  logic              i_mem_memread,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_wb_regwrite,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_branch_flag,
  output logic              o_cmp_en,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_stall,
  output logic              o_pc_sel,
  output logic              o_flush_if_id,
  output logic [CNT_W-1:0]  o_br_count,
  output logic [CNT_W-1:0]  o_taken_count,
  output logic [CNT_W-1:0]  o_stall_count
);

  localparam logic S_IDLE   = 1'b0;
  localparam logic S_LDWAIT = 1'b1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_state;
  logic             w_next_state;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_taken_count;
  logic [CNT_W-1:0] r_stall_count;

  logic w_br;
  logic w_ex_wr, w_mem_wr, w_wb_wr;
  logic w_ex_dep, w_mem_dep;
  logic w_mem_fwd_a, w_mem_fwd_b, w_wb_fwd_a, w_wb_fwd_b;
  logic [1:0] w_fwd_a_sel, w_fwd_b_sel;

  assign w_br = i_id_valid & i_id_branch;

  // x0 is never a real producer, so a zero rd disqualifies the stage
  assign w_ex_wr  = i_ex_regwrite  & (i_ex_rd  != '0);
  assign w_mem_wr = i_mem_regwrite & (i_mem_rd != '0);
  assign w_wb_wr  = i_wb_regwrite  & (i_wb_rd  != '0);

  assign w_ex_dep  = w_ex_wr  & ((i_ex_rd  == i_id_rs1) | (i_ex_rd  == i_id_rs2));
  assign w_mem_dep = w_mem_wr & ((i_mem_rd == i_id_rs1) | (i_mem_rd == i_id_rs2));

  // A load in MEM has no data yet, so only ALU results forward from MEM
  assign w_mem_fwd_a = w_mem_wr & ~i_mem_memread & (i_mem_rd == i_id_rs1);
  assign w_mem_fwd_b = w_mem_wr & ~i_mem_memread & (i_mem_rd == i_id_rs2);
  assign w_wb_fwd_a  = w_wb_wr & (i_wb_rd == i_id_rs1);
  assign w_wb_fwd_b  = w_wb_wr & (i_wb_rd == i_id_rs2);

  assign w_fwd_a_sel = w_mem_fwd_a ? FWD_MEM : (w_wb_fwd_a ? FWD_WB : FWD_RF);
  assign w_fwd_b_sel = w_mem_fwd_b ? FWD_MEM : (w_wb_fwd_b ? FWD_WB : FWD_RF);

  // Outputs are zero during reset and hold; hold also freezes the state.
  always_comb begin
    w_next_state  = r_state;
    o_stall       = 1'b0;
    o_cmp_en      = 1'b0;
    o_pc_sel      = 1'b0;
    o_flush_if_id = 1'b0;
    o_fwd_a       = FWD_RF;
    o_fwd_b       = FWD_RF;
    if (i_rst && !i_hold) begin
      case (r_state)
        S_LDWAIT: begin
          o_stall      = 1'b1;
          w_next_state = S_IDLE;
        end
        default: begin
          if (w_br) begin
            if (w_ex_dep && i_ex_memread) begin
              o_stall      = 1'b1;
              w_next_state = S_LDWAIT;
            end else if (w_ex_dep) begin
              o_stall = 1'b1;
            end else if (w_mem_dep && i_mem_memread) begin
              o_stall = 1'b1;
            end else begin
              o_cmp_en      = 1'b1;
              o_pc_sel      = i_branch_flag;
              o_flush_if_id = i_branch_flag;
              o_fwd_a       = w_fwd_a_sel;
              o_fwd_b       = w_fwd_b_sel;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_br_count    <= '0;
      r_taken_count <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (o_cmp_en && (r_br_count != '1))
        r_br_count <= r_br_count + CNT_ONE;
      if (o_cmp_en && i_branch_flag && (r_taken_count != '1))
        r_taken_count <= r_taken_count + CNT_ONE;
      if (o_stall && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_ONE;
    end
  end

  assign o_br_count    = r_br_count;
  assign o_taken_count = r_taken_count;
  assign o_stall_count = r_stall_count;

endmodule
